// File: rtl/meas_sequencer.sv
// meas_sequencer
//   Command-driven ring-oscillator frequency measurement sequencer. A UART
//   command starts a measurement: the RO is warmed up with its counter held
//   in clear, the counter is gated for a fixed window, the synchroniser is
//   allowed to settle, and the 16-bit count is sent back MSB first as two
//   bytes. Continuous mode repeats the measurement until a stop command.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   rx_data    command byte from the UART receiver
//   rx_valid   one-cycle strobe qualifying rx_data
//   cnt_value  RO edge count, already synchronised to clk
//   tx_busy    UART transmitter busy
//   ro_en      ring-oscillator enable
//   cnt_clear  synchronous clear for the RO counter
//   cnt_gate   RO counter count-enable window
//   tx_data    byte presented to the UART transmitter
//   tx_start   one-cycle transmit strobe
//   busy       high whenever a measurement or its transmission is in progress
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a start command
// SETTLE  | RO running, counter held in clear, SETTLE_CYCLES long
// GATE    | counter enabled, GATE_CYCLES long
// HOLD    | gate closed, 2 cycles for synchroniser latency; result captured
// TX_HI   | waiting for transmitter idle, then strobe result[15:8]
// WAIT_HI | one guard cycle, then wait for transmitter idle
// TX_LO   | waiting for transmitter idle, then strobe result[7:0]
// WAIT_LO | one guard cycle, then wait for idle; repeat or return to IDLE

module meas_sequencer #(
    parameter int unsigned GATE_CYCLES   = 1000,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic [15:0] cnt_value,
    input  logic        tx_busy,
    output logic        ro_en,
    output logic        cnt_clear,
    output logic        cnt_gate,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic        busy
);

    localparam logic [7:0] CMD_SINGLE = 8'h00;
    localparam logic [7:0] CMD_CONT   = 8'h01;
    localparam logic [7:0] CMD_STOP   = 8'h02;

    // Down-counter reload values; the state ends on the cycle the timer reads 0.
    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] GATE_LOAD   = 16'(GATE_CYCLES - 1);
    localparam logic [15:0] HOLD_LOAD   = 16'd1;
    localparam logic [15:0] GUARD_LOAD  = 16'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_GATE,
        S_HOLD,
        S_TX_HI,
        S_WAIT_HI,
        S_TX_LO,
        S_WAIT_LO
    } state_t;

    state_t      state;
    logic [15:0] timer;
    logic [15:0] result;
    logic [7:0]  tx_hold;
    logic        cont;

    logic        cmd_start;
    logic        cmd_stop;
    logic        tx_slot;
    logic [7:0]  tx_byte;

    assign cmd_start = rx_valid && ((rx_data == CMD_SINGLE) || (rx_data == CMD_CONT));
    assign cmd_stop  = rx_valid && (rx_data == CMD_STOP);

    // The strobe follows tx_busy in the same cycle so a byte goes out on the
    // first idle cycle of the transmitter, which keeps the first-byte latency
    // at exactly 1 + SETTLE + GATE + 2. Reset masks it so an aborted sequence
    // never leaks a strobe in the reset cycle itself.
    assign tx_slot  = ((state == S_TX_HI) || (state == S_TX_LO)) && !tx_busy && !reset;
    assign tx_byte  = (state == S_TX_HI) ? result[15:8] : result[7:0];
    assign tx_start = tx_slot;
    // tx_data only changes on a strobe; otherwise the last sent byte is held.
    assign tx_data  = tx_slot ? tx_byte : tx_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            timer     <= 16'd0;
            result    <= 16'd0;
            tx_hold   <= 8'h00;
            cont      <= 1'b0;
            ro_en     <= 1'b0;
            cnt_clear <= 1'b0;
            cnt_gate  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (tx_slot) begin
                tx_hold <= tx_byte;
            end
            if (cmd_stop) begin
                cont <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (cmd_start) begin
                        state     <= S_SETTLE;
                        timer     <= SETTLE_LOAD;
                        cont      <= (rx_data == CMD_CONT);
                        ro_en     <= 1'b1;
                        cnt_clear <= 1'b1;
                        cnt_gate  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end

                S_SETTLE: begin
                    if (timer == 16'd0) begin
                        state     <= S_GATE;
                        timer     <= GATE_LOAD;
                        cnt_clear <= 1'b0;
                        cnt_gate  <= 1'b1;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end

                S_GATE: begin
                    if (timer == 16'd0) begin
                        state    <= S_HOLD;
                        timer    <= HOLD_LOAD;
                        cnt_gate <= 1'b0;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end

                S_HOLD: begin
                    if (timer == 16'd0) begin
                        result <= cnt_value;
                        state  <= S_TX_HI;
                        timer  <= 16'd0;
                        ro_en  <= 1'b0;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end

                S_TX_HI: begin
                    if (!tx_busy) begin
                        state <= S_WAIT_HI;
                        timer <= GUARD_LOAD;
                    end
                end

                // The guard cycle covers the cycle where the transmitter has
                // not yet raised tx_busy in response to the strobe.
                S_WAIT_HI: begin
                    if (timer != 16'd0) begin
                        timer <= timer - 16'd1;
                    end else if (!tx_busy) begin
                        state <= S_TX_LO;
                        timer <= 16'd0;
                    end
                end

                S_TX_LO: begin
                    if (!tx_busy) begin
                        state <= S_WAIT_LO;
                        timer <= GUARD_LOAD;
                    end
                end

                S_WAIT_LO: begin
                    if (timer != 16'd0) begin
                        timer <= timer - 16'd1;
                    end else if (!tx_busy) begin
                        // A stop arriving on this very cycle wins over cont.
                        if (cont && !cmd_stop) begin
                            state     <= S_SETTLE;
                            timer     <= SETTLE_LOAD;
                            ro_en     <= 1'b1;
                            cnt_clear <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                            timer <= 16'd0;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    timer     <= 16'd0;
                    ro_en     <= 1'b0;
                    cnt_clear <= 1'b0;
                    cnt_gate  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_meas_sequencer.sv
// tb_meas_sequencer
//   Directed bench for meas_sequencer. A timeline model predicts every
//   output cycle by cycle from measurement start times and transmitter
//   handshake events; a small UART stand-in produces tx_busy after each
//   strobe. Literal expectations pin latency and byte values.

module tb_meas_sequencer;

    localparam int S = 16;
    localparam int G = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] cnt_value;
    wire  logic  tx_busy;
    logic        ro_en;
    logic        cnt_clear;
    logic        cnt_gate;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    bit force_busy = 1'b0;
    int uart_len   = 0;
    int uart_cnt   = 0;
    bit saw_start  = 1'b0;

    logic [7:0] got_bytes[$];
    int         got_cyc[$];

    // model state
    bit          m_active = 1'b0;
    bit          m_cont   = 1'b0;
    int          m_t0     = 0;
    int          hi_t     = -1;
    int          lo_ready = -1;
    int          lo_t     = -1;
    logic [15:0] m_result = 16'h0000;
    logic [7:0]  m_last   = 8'h00;

    assign tx_busy = force_busy || (uart_cnt > 0);

    meas_sequencer #(.GATE_CYCLES(G), .SETTLE_CYCLES(S)) dut (
        .clk(clk),
        .reset(reset),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .cnt_value(cnt_value),
        .tx_busy(tx_busy),
        .ro_en(ro_en),
        .cnt_clear(cnt_clear),
        .cnt_gate(cnt_gate),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit hi_open(input int c);
        return m_active && ((c - m_t0) >= S + G + 2) && (hi_t < 0);
    endfunction

    function automatic bit lo_open(input int c);
        return m_active && (lo_ready >= 0) && (c >= lo_ready) && (lo_t < 0);
    endfunction

    // Timeline model: advances at each rising edge using the inputs of the
    // cycle that is ending.
    initial begin
        int  c;
        int  d;
        bit  stop;
        bit  start;
        forever begin
            @(posedge clk);
            c = cyc;
            if (reset) begin
                m_active = 1'b0;
                m_cont   = 1'b0;
                m_result = 16'h0000;
                m_last   = 8'h00;
            end else begin
                stop  = rx_valid && (rx_data == 8'h02);
                start = rx_valid && ((rx_data == 8'h00) || (rx_data == 8'h01));
                if (stop) m_cont = 1'b0;
                if (!m_active) begin
                    if (start) begin
                        m_active = 1'b1;
                        m_t0     = c + 1;
                        m_cont   = (rx_data == 8'h01);
                        hi_t     = -1;
                        lo_ready = -1;
                        lo_t     = -1;
                    end
                end else begin
                    d = c - m_t0;
                    if (d == S + G + 1) m_result = cnt_value;
                    if (hi_open(c) && !tx_busy) begin
                        hi_t   = c;
                        m_last = m_result[15:8];
                    end else if (hi_t >= 0 && lo_ready < 0 && c >= hi_t + 2 && !tx_busy) begin
                        lo_ready = c + 1;
                    end else if (lo_open(c) && !tx_busy) begin
                        lo_t   = c;
                        m_last = m_result[7:0];
                    end else if (lo_t >= 0 && c >= lo_t + 2 && !tx_busy) begin
                        if (m_cont) begin
                            m_t0     = c + 1;
                            hi_t     = -1;
                            lo_ready = -1;
                            lo_t     = -1;
                        end else begin
                            m_active = 1'b0;
                        end
                    end
                end
            end
            cyc = cyc + 1;
        end
    end

    // Compare process and strobe recorder, mid-cycle.
    initial begin
        int         d;
        bit         sh;
        bit         sl;
        bit         e_start;
        logic [7:0] e_data;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                d       = cyc - m_t0;
                sh      = hi_open(cyc);
                sl      = lo_open(cyc);
                e_start = !reset && !tx_busy && (sh || sl);
                e_data  = !e_start ? m_last : (sh ? m_result[15:8] : m_result[7:0]);
                chk("busy", busy, m_active);
                chk("ro_en", ro_en, m_active && d < S + G + 2);
                chk("cnt_clear", cnt_clear, m_active && d < S);
                chk("cnt_gate", cnt_gate, m_active && d >= S && d < S + G);
                chk("tx_start", tx_start, e_start);
                chk("tx_data", tx_data, e_data);
            end
            saw_start = (tx_start === 1'b1);
            if (saw_start) begin
                got_bytes.push_back(tx_data);
                got_cyc.push_back(cyc);
            end
        end
    end

    // UART stand-in: busy for uart_len cycles starting the cycle after a strobe.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (saw_start) uart_cnt = uart_len;
            else if (uart_cnt > 0) uart_cnt = uart_cnt - 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cycle(input int t);
        int guard;
        guard = 0;
        while (cyc < t && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
        end
    endtask

    task automatic send_cmd(input logic [7:0] b, output int at);
        rx_data  = b;
        rx_valid = 1'b1;
        at       = cyc;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (got_bytes.size() < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (got_bytes.size() < n) begin
            checks++;
            failures++;
            $display("FAIL %s timeout strobes got=%0d expected=%0d", name, got_bytes.size(), n);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({name, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        int         r;
        int         n0;
        int         t;
        logic [7:0] exp6[6];
        exp6 = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h01, 8'h02};

        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        cnt_value = 16'h0000;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        tick(2);
        reset = 1'b0;

        // reset values
        chk("rst_busy", busy, 1'b0);
        chk("rst_ro_en", ro_en, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_tx_start", tx_start, 1'b0);

        // illegal command
        send_cmd(8'h7F, r);
        tick(20);
        chk("illegal_busy", busy, 1'b0);
        chk("illegal_ro_en", ro_en, 1'b0);

        // single measurement
        uart_len  = 12;
        cnt_value = 16'h1234;
        n0 = got_bytes.size();
        send_cmd(8'h00, r);
        wait_strobes(n0 + 2, 1300, "single");
        chk("single_latency", got_cyc[n0] - r, 1019);
        chk("single_hi", got_bytes[n0], 8'h12);
        chk("single_lo", got_bytes[n0 + 1], 8'h34);
        wait_idle(100, "single");
        tick(30);
        chk("single_count", got_bytes.size() - n0, 2);

        // continuous mode, stop during the third gate
        uart_len  = 20;
        cnt_value = 16'h0100;
        n0 = got_bytes.size();
        send_cmd(8'h01, r);
        for (int k = 0; k < 3; k++) begin
            wait_strobes(n0 + 2 * k + 2, 1400, "cont");
            cnt_value = 16'h0100 + 16'(k + 1);
            if (k == 1) begin
                tick(500);
                send_cmd(8'h02, r);
            end
        end
        wait_idle(200, "cont");
        tick(50);
        chk("cont_count", got_bytes.size() - n0, 6);
        for (int i = 0; i < 6; i++) chk("cont_byte", got_bytes[n0 + i], exp6[i]);

        // transmitter backpressure at TX_HI entry
        uart_len  = 12;
        cnt_value = 16'hA55A;
        n0 = got_bytes.size();
        send_cmd(8'h00, r);
        wait_cycle(r + 1019);
        force_busy = 1'b1;
        wait_cycle(r + 1519);
        force_busy = 1'b0;
        wait_strobes(n0 + 2, 200, "bp");
        chk("bp_hi_cycle", got_cyc[n0] - r, 1519);
        chk("bp_hi", got_bytes[n0], 8'hA5);
        chk("bp_lo", got_bytes[n0 + 1], 8'h5A);
        wait_idle(100, "bp");
        tick(30);
        chk("bp_count", got_bytes.size() - n0, 2);

        // start command while busy is dropped
        cnt_value = 16'h0F0F;
        n0 = got_bytes.size();
        send_cmd(8'h00, r);
        wait_cycle(r + 500);
        send_cmd(8'h00, t);
        wait_strobes(n0 + 2, 1300, "drop");
        wait_idle(100, "drop");
        tick(40);
        chk("drop_count", got_bytes.size() - n0, 2);
        chk("drop_lo", got_bytes[n0 + 1], 8'h0F);

        // reset during GATE aborts
        cnt_value = 16'h7777;
        n0 = got_bytes.size();
        send_cmd(8'h00, r);
        wait_cycle(r + 400);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("abort_ro_en", ro_en, 1'b0);
        chk("abort_gate", cnt_gate, 1'b0);
        chk("abort_clear", cnt_clear, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_tx_data", tx_data, 8'h00);
        tick(1100);
        chk("abort_count", got_bytes.size() - n0, 0);
        cnt_value = 16'hBEEF;
        send_cmd(8'h00, r);
        wait_strobes(n0 + 2, 1300, "after_abort");
        chk("after_abort_latency", got_cyc[n0] - r, 1019);
        chk("after_abort_hi", got_bytes[n0], 8'hBE);
        chk("after_abort_lo", got_bytes[n0 + 1], 8'hEF);
        wait_idle(100, "after_abort");

        // stop coinciding with the WAIT_LO exit cycle
        uart_len  = 0;
        cnt_value = 16'h4242;
        tick(5);
        n0 = got_bytes.size();
        send_cmd(8'h01, r);
        wait_strobes(n0 + 2, 1300, "edge_stop");
        t = got_cyc[n0 + 1];
        wait_cycle(t + 2);
        send_cmd(8'h02, r);
        chk("edge_stop_busy", busy, 1'b0);
        tick(50);
        chk("edge_stop_count", got_bytes.size() - n0, 2);
        chk("edge_stop_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/meas_sequencer.md
MEAS_SEQUENCER -- requirements
Module: meas_sequencer

Interface
REQ-001 Parameter GATE_CYCLES, default 1000, gate-window length in clk cycles; legal range 1..65535.
REQ-002 Parameter SETTLE_CYCLES, default 16, RO warm-up length in clk cycles; legal range 1..255.
REQ-003 Port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port rx_data  input  8  command byte from the UART receiver.
REQ-006 Port rx_valid  input  1  one-cycle strobe; rx_data is valid in the same cycle.
REQ-007 Port cnt_value  input  16  ring-oscillator edge count, already synchronised to clk.
REQ-008 Port tx_busy  input  1  UART transmitter busy; high from the cycle after tx_start until the byte completes.
REQ-009 Port ro_en  output  1  ring-oscillator enable.
REQ-010 Port cnt_clear  output  1  synchronous clear for the RO counter.
REQ-011 Port cnt_gate  output  1  RO counter count-enable window.
REQ-012 Port tx_data  output  8  byte presented to the UART transmitter.
REQ-013 Port tx_start  output  1  one-cycle transmit strobe.
REQ-014 Port busy  output  1  high in every state except IDLE.

Function
REQ-015 Commands: 0x00 = single measurement; 0x01 = continuous mode; 0x02 = stop continuous mode; all other bytes are ignored.
REQ-016 States: IDLE, SETTLE, GATE, HOLD, TX_HI, WAIT_HI, TX_LO, WAIT_LO.
REQ-017 IDLE: on rx_valid with 0x00 or 0x01, enter SETTLE on the next cycle; with 0x01, also set the cont flag.
REQ-018 SETTLE: ro_en=1 and cnt_clear=1 for exactly SETTLE_CYCLES cycles, then enter GATE.
REQ-019 GATE: ro_en=1, cnt_gate=1 and cnt_clear=0 for exactly GATE_CYCLES cycles, then enter HOLD.
REQ-020 HOLD: ro_en=1 and cnt_gate=0 for exactly 2 cycles (counter synchroniser latency).
REQ-021 Result capture: cnt_value is latched into a 16-bit result register on the last HOLD cycle.
REQ-022 TX_HI: wait while tx_busy=1; in the first cycle with tx_busy=0, assert tx_start for 1 cycle with tx_data=result[15:8], then enter WAIT_HI.
REQ-023 WAIT_HI: ignore tx_busy for 1 guard cycle, then wait for tx_busy=0 and enter TX_LO.
REQ-024 TX_LO/WAIT_LO: same sequence as TX_HI/WAIT_HI with tx_data=result[7:0].
REQ-025 Leaving WAIT_LO: go to SETTLE if cont=1, else to IDLE.
REQ-026 tx_data holds its last value outside tx_start cycles.
REQ-027 ro_en=0 in TX_*, WAIT_* and IDLE states.
REQ-028 cnt_gate and cnt_clear are never high in the same cycle.
REQ-029 Command 0x02, accepted in any state: clears cont next cycle; the measurement in progress completes and transmits both bytes.
REQ-030 Command 0x00 or 0x01 received while busy=1 is dropped; cont is not set.
REQ-031 rx_valid coinciding with the WAIT_LO exit cycle: 0x02 takes priority, so the block goes to IDLE.
REQ-032 Internal cycle counter: 16 bits, reloaded on every state entry; it never wraps inside a state.
REQ-033 Latency from rx_valid (cycle 0) to the first tx_start, with tx_busy=0: 1 + SETTLE_CYCLES + GATE_CYCLES + 2 cycles.

Reset
REQ-034 While reset=1 at a rising edge: state=IDLE, cont=0, result=0, tx_data=0x00, and ro_en, cnt_clear, cnt_gate, tx_start, busy are all 0 from the next cycle.
REQ-035 Reset mid-measurement or mid-transmission aborts immediately; no further tx_start is issued.
REQ-036 reset has priority over rx_valid in the same cycle.

Verification
REQ-037 Single measurement: reset, then rx 0x00 with GATE_CYCLES=1000, SETTLE_CYCLES=16, cnt_value=0x1234 at capture -> tx_start with 0x12, then 0x34, then IDLE; first tx_start exactly 1019 cycles after rx_valid.
REQ-038 Continuous mode: rx 0x01, cnt_value stepping 0x0100, 0x0101, 0x0102 -> bytes 01 00 01 01 01 02 in order; rx 0x02 during the third GATE -> third pair still sent, then IDLE.
REQ-039 Transmitter backpressure: hold tx_busy=1 for 500 cycles at TX_HI entry -> tx_start issued in the first cycle after tx_busy falls; no duplicate strobes.
REQ-040 Busy drop: rx 0x00 during GATE -> ignored; exactly one byte pair sent.
REQ-041 Reset abort: reset=1 for 1 cycle during GATE -> all outputs 0 next cycle; no tx_start; rx 0x00 afterwards -> normal measurement.
REQ-042 Illegal command: rx 0x7F in IDLE -> outputs stay at reset values and busy stays 0.
